// File: rtl/coherence_bus_arbiter_pkg.sv
// Shared types and constants for the snooping-bus arbiter.
// The arbiter's optional grant timeout is enabled by defining ARB_TIMEOUT_EN.
package coherence_bus_arbiter_pkg;

  localparam int unsigned N_CORES   = 2;
  localparam int unsigned N_BUS_REQ = 2 * N_CORES;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ARB_IDLE  = 2'd0;
  localparam arb_state_t ARB_GRANT = 2'd1;
  localparam arb_state_t ARB_HOLD  = 2'd2;

  // Index width that stays legal for a single requester.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/coherence_bus_arbiter_rr_picker.sv
// Rotate-priority encoder: first set request at index >= ptr, wrapping to 0.
module coherence_bus_arbiter_rr_picker
  import coherence_bus_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = N_BUS_REQ,
  localparam int unsigned IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any_c,
  output logic [IDX_W-1:0] idx_c
);

  int unsigned cand;

  always_comb begin
    any_c = 1'b0;
    idx_c = '0;
    cand  = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = 32'(ptr) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!any_c && req[IDX_W'(cand)]) begin
        any_c = 1'b1;
        idx_c = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/coherence_bus_arbiter.sv
// Round-robin arbiter for one shared snooping bus; broadcasts the owner's message while busy.
// Define ARB_TIMEOUT_EN to revoke grants that sit unused for TIMEOUT_CYC cycles.
module coherence_bus_arbiter
  import coherence_bus_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ       = N_BUS_REQ,
  parameter int unsigned MSG_W       = 64,
  parameter int unsigned TIMEOUT_CYC = 16,
  localparam int unsigned IDX_W      = idx_width(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       busy,
  input  logic [N_REQ*MSG_W-1:0] tx,
  output logic [N_REQ-1:0]       gnt,
  output logic [MSG_W-1:0]       bus_msg,
  output logic                   bus_valid,
  output logic [IDX_W-1:0]       bus_owner,
  output logic                   timeout_err
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

  arb_state_t        state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [MSG_W-1:0]  msg_q, msg_d;
  logic              valid_q, valid_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;

  logic              pick_any;
  logic [IDX_W-1:0]  pick_idx;
  logic              own_busy;
  logic              own_req;
  logic [MSG_W-1:0]  own_tx;
  logic [IDX_W-1:0]  nxt_ptr;

`ifdef ARB_TIMEOUT_EN
  logic [TMO_W-1:0]  cnt_q, cnt_d;
  logic              terr_q, terr_d;
`endif

  coherence_bus_arbiter_rr_picker #(.N_REQ(N_REQ)) u_picker (
    .req   (req),
    .ptr   (ptr_q),
    .any_c (pick_any),
    .idx_c (pick_idx)
  );

  // Owner-side view of the request ports and the pointer past the owner.
  always_comb begin
    own_busy = busy[owner_q];
    own_req  = req[owner_q];
    own_tx   = tx[32'(owner_q)*MSG_W +: MSG_W];
    nxt_ptr  = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    msg_d   = msg_q;
    valid_d = 1'b0;
    owner_d = owner_q;
    ptr_d   = ptr_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    terr_d  = 1'b0;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          state_d = ARB_GRANT;
          gnt_d   = N_REQ'(1) << pick_idx;
          owner_d = pick_idx;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ARB_GRANT: begin
        if (own_busy) begin
          state_d = ARB_HOLD;
          msg_d   = own_tx;
          valid_d = 1'b1;
        end else if (!own_req) begin
          state_d = ARB_IDLE;
          gnt_d   = '0;
          ptr_d   = nxt_ptr;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == TMO_W'(TIMEOUT_CYC - 1)) begin
          state_d = ARB_IDLE;
          gnt_d   = '0;
          ptr_d   = nxt_ptr;
          terr_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + TMO_W'(1);
        end
`endif
      end
      ARB_HOLD: begin
        if (own_busy) begin
          msg_d   = own_tx;
          valid_d = 1'b1;
        end else begin
          state_d = ARB_IDLE;
          gnt_d   = '0;
          ptr_d   = nxt_ptr;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      msg_q   <= '0;
      valid_q <= 1'b0;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      msg_q   <= msg_d;
      valid_q <= valid_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q  <= '0;
      terr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      terr_q <= terr_d;
    end
  end

  assign timeout_err = terr_q;
`else
  logic [TMO_W-1:0] unused_tmo_cfg;
  assign unused_tmo_cfg = TMO_W'(TIMEOUT_CYC);
  assign timeout_err    = 1'b0;
`endif

  assign gnt       = gnt_q;
  assign bus_msg   = msg_q;
  assign bus_valid = valid_q;
  assign bus_owner = owner_q;

endmodule
